dstack_spill_ctrl: RTL and testbench
====================================

Name: dstack_spill_ctrl

Overview:
Sequences spill and fill traffic between the core's on-chip data-stack register array and a backing memory region. It consumes the per-cycle stack `movement` decoded from the instruction and tracks on-chip and spilled depth. It spills the bottom entry to memory above a high-water mark and refills from memory below a low-water mark. It stalls the core only when an operation cannot complete with the on-chip entries available.

Parameters:
WORD_WIDTH, 32, data and address word width
DEPTH, 16, on-chip stack entries including top; counts are $clog2(DEPTH+1) bits
HIGH_WATER, 12, spill starts when onchip_count > HIGH_WATER; legal range 2 <= HIGH_WATER <= DEPTH-1
LOW_WATER, 4, fill starts when onchip_count < LOW_WATER and spilled_count > 0; must be < HIGH_WATER
SPILL_BITS, 16, width of spilled_count

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
movement  in  2  00 none, 01 push, 10 pop, 11 pop two
move_valid  in  1  movement applies this cycle; low during halt
stall  out  1  combinational; core must hold the instruction this cycle
spill_base  in  WORD_WIDTH  word address of the spill region base
bottom_value  in  WORD_WIDTH  current deepest on-chip entry
mem_req  out  1  memory request
mem_we  out  1  1 = spill write, 0 = fill read
mem_addr  out  WORD_WIDTH  request word address
mem_wdata  out  WORD_WIDTH  spill data
mem_ack  in  1  request accepted and completed this cycle; mem_rdata valid
mem_rdata  in  WORD_WIDTH  fill data
drop_bottom  out  1  one-cycle pulse: array discards its bottom entry
fill_valid  out  1  one-cycle pulse: array appends fill_value below its bottom
fill_value  out  WORD_WIDTH  registered fill data
onchip_count  out  $clog2(DEPTH+1)  valid on-chip entries (N)
spilled_count  out  SPILL_BITS  entries held in memory (S)
underflow  out  1  sticky; set when a pop exceeds N+S

Behaviour:
- Reset, synchronous: N=0, S=0, FSM=IDLE. mem_req, mem_we, drop_bottom, fill_valid, underflow all 0. mem_addr, mem_wdata and fill_value are 0.
- A reset mid-request abandons the request. mem_req is 0 from the next cycle and no pulse is emitted.
- Movement delta, taken only when move_valid && !stall: push +1, pop -1, pop-two -2.
- stall = move_valid && (push with N==DEPTH, or pop with N==0 && S>0, or pop-two with N<2 && N+S>=2).
- If a pop or pop-two needs more than N+S entries: no stall, N saturates at 0, and underflow is set.
- FSM IDLE, spill:
  - If N > HIGH_WATER, go to SPILL.
  - Register mem_addr = spill_base + S, mem_wdata = bottom_value, and mem_we = 1.
  - mem_req is asserted the cycle after the decision.
- FSM IDLE, fill:
  - Else if N < LOW_WATER && S > 0, go to FILL.
  - Register mem_addr = spill_base + S - 1 and mem_we = 0.
- FSM IDLE, spill_base: sampled only in IDLE.
- SPILL:
  - Hold mem_req, mem_addr and mem_wdata stable until mem_ack.
  - On the ack edge: S += 1, N -= 1 (plus any movement delta the same cycle), mem_req = 0, return to IDLE.
  - Next cycle: drop_bottom = 1.
- FILL:
  - Hold the request until mem_ack.
  - On the ack edge: fill_value <= mem_rdata, S -= 1, N += 1 (plus movement delta), return to IDLE.
  - Next cycle: fill_valid = 1.
- The stall decision uses the start-of-cycle N, so a pop at N==0 stalls even in a fill's ack cycle.
- Back-to-back: IDLE evaluates the new N on the cycle after return. The minimum spacing between requests is 1 idle cycle.
- Spill priority over fill can never be exercised because LOW_WATER < HIGH_WATER.
- Pushes and pops during SPILL are legal. mem_wdata was captured at entry, so bottom shifts do not corrupt it.
- S saturates at 2^SPILL_BITS-1; with S saturated, the spill trigger is suppressed.
- All counters are unsigned; address arithmetic is modulo 2^WORD_WIDTH.

Test Plan:
1. Reset, then 13 pushes, spill_base=0x1000, bottom_value=0xA5 → mem_req a cycle after N=13, we=1, addr=0x1000, wdata=0xA5. With ack after 3 cycles → drop_bottom pulse, N=12, S=1.
2. With N=4, S=2, pop → N=3, FILL at addr=0x1001. Ack with rdata=0xBEEF → fill_valid and fill_value=0xBEEF next cycle, N=4, S=1.
3. N=16 and a push during pending spill → stall=1 until the ack cycle. The push completes the cycle after, giving N=16-1+1=16.
4. N=0, S=3, pop → stall held until the fill completes, then the pop proceeds. N=0, S=0, pop-two → no stall, underflow=1, N=0.
5. Reset asserted while mem_req=1 in FILL → next cycle mem_req=0 and N=S=0. A late mem_ack produces no fill_valid.
6. Pop-two and spill ack in the same cycle with N=14 → N=11, S+1, no stall.

Source files
------------

// File: rtl/dstack_spill_ctrl.sv
// -----------------------------------------------------------------------------
// dstack_spill_ctrl
//
// Sequences spill and fill traffic between the core's on-chip data-stack
// register array and a backing memory region. Tracks the on-chip depth (N)
// and the number of entries parked in memory (S). When N rises above
// HIGH_WATER the deepest on-chip entry is written out; when N falls below
// LOW_WATER and memory holds entries, the most recently spilled entry is read
// back and appended below the on-chip bottom.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   movement, move_valid  per-cycle stack movement (00 none, 01 push,
//                         10 pop, 11 pop two); move_valid low during halt
//   stall                 combinational; core must hold its instruction
//   spill_base            word address of the spill region (sampled in IDLE)
//   bottom_value          current deepest on-chip entry
//   mem_req/we/addr/wdata memory request (we=1 spill write, we=0 fill read)
//   mem_ack, mem_rdata    request completed this cycle, fill read data
//   drop_bottom           one-cycle pulse: array discards its bottom entry
//   fill_valid/value      one-cycle pulse: array appends fill_value below bottom
//   onchip_count          N, valid on-chip entries
//   spilled_count         S, entries held in memory
//   underflow             sticky; a pop asked for more than N+S entries
// -----------------------------------------------------------------------------
module dstack_spill_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4,
    parameter int SPILL_BITS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   movement,
    input  logic                         move_valid,
    output logic                         stall,
    input  logic [WORD_WIDTH-1:0]        spill_base,
    input  logic [WORD_WIDTH-1:0]        bottom_value,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [WORD_WIDTH-1:0]        mem_addr,
    output logic [WORD_WIDTH-1:0]        mem_wdata,
    input  logic                         mem_ack,
    input  logic [WORD_WIDTH-1:0]        mem_rdata,
    output logic                         drop_bottom,
    output logic                         fill_valid,
    output logic [WORD_WIDTH-1:0]        fill_value,
    output logic [$clog2(DEPTH+1)-1:0]   onchip_count,
    output logic [SPILL_BITS-1:0]        spilled_count,
    output logic                         underflow
);

    localparam int CW   = $clog2(DEPTH + 1);
    // Headroom for N arithmetic: +2 covers push plus fill in one cycle
    // and lets a negative intermediate be detected before saturation.
    localparam int NW   = CW + 2;
    localparam int SUMW = ((SPILL_BITS > CW) ? SPILL_BITS : CW) + 1;

    localparam logic [SPILL_BITS-1:0] S_MAX  = {SPILL_BITS{1'b1}};
    localparam logic [SPILL_BITS-1:0] S_ZERO = {SPILL_BITS{1'b0}};
    localparam logic [CW-1:0]         N_ZERO = {CW{1'b0}};
    localparam logic [WORD_WIDTH-1:0] W_ZERO = {WORD_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SPILL = 2'b01,
        ST_FILL  = 2'b10
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [CW-1:0]           r_n;
    logic [SPILL_BITS-1:0]   r_s;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [WORD_WIDTH-1:0]   r_mem_addr;
    logic [WORD_WIDTH-1:0]   r_mem_wdata;
    logic                    r_drop;
    logic                    r_fill_valid;
    logic [WORD_WIDTH-1:0]   r_fill_value;
    logic                    r_underflow;

    logic                    w_push;
    logic                    w_pop1;
    logic                    w_pop2;
    logic                    w_stall;
    logic                    w_push_go;
    logic                    w_pop1_go;
    logic                    w_pop2_go;
    logic                    w_underflow_ev;
    logic [SUMW-1:0]         w_avail;
    logic                    w_spill_ack;
    logic                    w_fill_ack;
    logic                    w_spill_go;
    logic                    w_fill_go;
    logic [NW-1:0]           w_n_up;
    logic [NW-1:0]           w_n_dn;
    logic [CW-1:0]           w_n_next;
    logic [SPILL_BITS-1:0]   w_s_next;
    logic                    w_req_next;
    logic                    w_we_next;
    logic [WORD_WIDTH-1:0]   w_addr_next;
    logic [WORD_WIDTH-1:0]   w_wdata_next;

    // Movement decode; only meaningful while move_valid is high.
    assign w_push = move_valid && (movement == 2'b01);
    assign w_pop1 = move_valid && (movement == 2'b10);
    assign w_pop2 = move_valid && (movement == 2'b11);

    // Total entries reachable by pops (on-chip plus spilled).
    assign w_avail = SUMW'(r_n) + SUMW'(r_s);

    // Stall only when the entries exist but are not yet on chip (or the
    // array is full). All terms use start-of-cycle N, so a completing fill
    // does not release a pop at N==0 in its own ack cycle.
    assign w_stall = (w_push && (r_n == CW'(DEPTH)))
                  || (w_pop1 && (r_n == N_ZERO) && (r_s != S_ZERO))
                  || (w_pop2 && (r_n < CW'(2)) && (w_avail >= SUMW'(2)));
    assign stall   = w_stall;

    assign w_push_go = w_push && !w_stall;
    assign w_pop1_go = w_pop1 && !w_stall;
    assign w_pop2_go = w_pop2 && !w_stall;

    // A pop that wants more entries than exist anywhere: never stalls
    // (stall requires the entries to exist), N saturates at zero.
    assign w_underflow_ev = (w_pop1_go && (w_avail == SUMW'(0)))
                         || (w_pop2_go && (w_avail < SUMW'(2)));

    assign w_spill_ack = (r_state == ST_SPILL) && mem_ack;
    assign w_fill_ack  = (r_state == ST_FILL)  && mem_ack;

    // Spill is suppressed when S can no longer count another entry.
    assign w_spill_go = (r_n > CW'(HIGH_WATER)) && (r_s != S_MAX);
    assign w_fill_go  = (r_n < CW'(LOW_WATER))  && (r_s != S_ZERO);

    // Next on-chip count: movement plus any spill/fill completion, clamped.
    always_comb begin
        w_n_up = NW'(r_n) + NW'(w_push_go) + NW'(w_fill_ack);
        w_n_dn = NW'(w_pop1_go) + (w_pop2_go ? NW'(2) : NW'(0)) + NW'(w_spill_ack);
        if (w_n_dn > w_n_up) begin
            w_n_next = N_ZERO;
        end else if ((w_n_up - w_n_dn) > NW'(DEPTH)) begin
            w_n_next = CW'(DEPTH);
        end else begin
            w_n_next = CW'(w_n_up - w_n_dn);
        end
    end

    // Next spilled count; spill and fill acks are mutually exclusive by state.
    always_comb begin
        if (w_spill_ack && (r_s != S_MAX)) begin
            w_s_next = r_s + SPILL_BITS'(1);
        end else if (w_fill_ack && (r_s != S_ZERO)) begin
            w_s_next = r_s - SPILL_BITS'(1);
        end else begin
            w_s_next = r_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; spill is checked first though the watermarks
    // make both conditions mutually exclusive.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_spill_go) begin
                    w_state_next = ST_SPILL;
                end else if (w_fill_go) begin
                    w_state_next = ST_FILL;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SPILL: begin
                if (mem_ack) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SPILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: request fields are loaded only on the IDLE decision
    // and then held, so bottom shifts during a spill cannot corrupt wdata.
    always_comb begin
        w_req_next   = (w_state_next != ST_IDLE);
        w_we_next    = r_mem_we;
        w_addr_next  = r_mem_addr;
        w_wdata_next = r_mem_wdata;
        if ((r_state == ST_IDLE) && (w_state_next == ST_SPILL)) begin
            w_we_next    = 1'b1;
            w_addr_next  = spill_base + WORD_WIDTH'(r_s);
            w_wdata_next = bottom_value;
        end else if ((r_state == ST_IDLE) && (w_state_next == ST_FILL)) begin
            w_we_next    = 1'b0;
            w_addr_next  = spill_base + WORD_WIDTH'(r_s) - WORD_WIDTH'(1);
            w_wdata_next = r_mem_wdata;
        end else begin
            w_we_next    = r_mem_we;
            w_addr_next  = r_mem_addr;
            w_wdata_next = r_mem_wdata;
        end
    end

    // Datapath registers: counters, request fields, pulses and sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n          <= N_ZERO;
            r_s          <= S_ZERO;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= W_ZERO;
            r_mem_wdata  <= W_ZERO;
            r_drop       <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_value <= W_ZERO;
            r_underflow  <= 1'b0;
        end else begin
            r_n          <= w_n_next;
            r_s          <= w_s_next;
            r_mem_req    <= w_req_next;
            r_mem_we     <= w_we_next;
            r_mem_addr   <= w_addr_next;
            r_mem_wdata  <= w_wdata_next;
            r_drop       <= w_spill_ack;
            r_fill_valid <= w_fill_ack;
            r_fill_value <= w_fill_ack ? mem_rdata : r_fill_value;
            r_underflow  <= r_underflow || w_underflow_ev;
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign drop_bottom   = r_drop;
    assign fill_valid    = r_fill_valid;
    assign fill_value    = r_fill_value;
    assign onchip_count  = r_n;
    assign spilled_count = r_s;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_dstack_spill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dstack_spill_ctrl
//
// Directed bench for dstack_spill_ctrl with default parameters. Inputs are
// driven 1 time unit after the rising edge; registered outputs are checked
// there, and the combinational stall one further unit later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dstack_spill_ctrl;

    localparam logic [1:0] MV_NONE = 2'b00;
    localparam logic [1:0] MV_PUSH = 2'b01;
    localparam logic [1:0] MV_POP  = 2'b10;
    localparam logic [1:0] MV_POP2 = 2'b11;

    logic        clk;
    logic        reset;
    logic [1:0]  movement;
    logic        move_valid;
    logic        stall;
    logic [31:0] spill_base;
    logic [31:0] bottom_value;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        drop_bottom;
    logic        fill_valid;
    logic [31:0] fill_value;
    logic [4:0]  onchip_count;
    logic [15:0] spilled_count;
    logic        underflow;

    int n_checks;
    int n_errors;

    dstack_spill_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .movement      (movement),
        .move_valid    (move_valid),
        .stall         (stall),
        .spill_base    (spill_base),
        .bottom_value  (bottom_value),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .drop_bottom   (drop_bottom),
        .fill_valid    (fill_valid),
        .fill_value    (fill_value),
        .onchip_count  (onchip_count),
        .spilled_count (spilled_count),
        .underflow     (underflow)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        movement     = MV_NONE;
        move_valid   = 1'b0;
        spill_base   = 32'h0000_1000;
        bottom_value = 32'h0000_00A5;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0000_0000;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state.
        chk_eq("rst_n",        64'(onchip_count),  64'd0);
        chk_eq("rst_s",        64'(spilled_count), 64'd0);
        chk_eq("rst_req",      64'(mem_req),       64'd0);
        chk_eq("rst_we",       64'(mem_we),        64'd0);
        chk_eq("rst_addr",     64'(mem_addr),      64'd0);
        chk_eq("rst_wdata",    64'(mem_wdata),     64'd0);
        chk_eq("rst_fval",     64'(fill_value),    64'd0);
        chk_eq("rst_drop",     64'(drop_bottom),   64'd0);
        chk_eq("rst_fvalid",   64'(fill_valid),    64'd0);
        chk_eq("rst_uflow",    64'(underflow),     64'd0);
        #1 chk_eq("rst_stall", 64'(stall),         64'd0);

        // 13 pushes cross the high-water mark; request follows one cycle later.
        movement = MV_PUSH; move_valid = 1'b1;
        repeat (13) cyc();
        movement = MV_NONE; move_valid = 1'b0;
        chk_eq("t1_n13",      64'(onchip_count), 64'd13);
        chk_eq("t1_noreq",    64'(mem_req),      64'd0);
        cyc();
        chk_eq("t1_req",      64'(mem_req),      64'd1);
        chk_eq("t1_we",       64'(mem_we),       64'd1);
        chk_eq("t1_addr",     64'(mem_addr),     64'h1000);
        chk_eq("t1_wdata",    64'(mem_wdata),    64'hA5);
        bottom_value = 32'h0000_005A;
        cyc();
        cyc();
        chk_eq("t1_req_hold", 64'(mem_req),      64'd1);
        chk_eq("t1_wd_hold",  64'(mem_wdata),    64'hA5);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk_eq("t1_req_off",  64'(mem_req),       64'd0);
        chk_eq("t1_drop",     64'(drop_bottom),   64'd1);
        chk_eq("t1_n12",      64'(onchip_count),  64'd12);
        chk_eq("t1_s1",       64'(spilled_count), 64'd1);
        cyc();
        chk_eq("t1_drop_off", 64'(drop_bottom),   64'd0);

        // Second spill to reach S=2, then pop down to N=4 and trigger a fill.
        movement = MV_PUSH; move_valid = 1'b1;
        cyc();
        movement = MV_NONE; move_valid = 1'b0;
        cyc();
        chk_eq("t2_sp_addr",  64'(mem_addr),      64'h1001);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        movement = MV_POP; move_valid = 1'b1;
        repeat (8) cyc();
        chk_eq("t2_n4",       64'(onchip_count),  64'd4);
        chk_eq("t2_s2",       64'(spilled_count), 64'd2);
        chk_eq("t2_noreq",    64'(mem_req),       64'd0);
        cyc();
        movement = MV_NONE; move_valid = 1'b0;
        chk_eq("t2_n3",       64'(onchip_count),  64'd3);
        cyc();
        chk_eq("t2_req",      64'(mem_req),       64'd1);
        chk_eq("t2_we",       64'(mem_we),        64'd0);
        chk_eq("t2_addr",     64'(mem_addr),      64'h1001);
        mem_rdata = 32'h0000_BEEF; mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk_eq("t2_fvalid",   64'(fill_valid),    64'd1);
        chk_eq("t2_fval",     64'(fill_value),    64'hBEEF);
        chk_eq("t2_n4b",      64'(onchip_count),  64'd4);
        chk_eq("t2_s1",       64'(spilled_count), 64'd1);
        chk_eq("t2_req_off",  64'(mem_req),       64'd0);
        cyc();
        chk_eq("t2_fv_off",   64'(fill_valid),    64'd0);

        // Fill the array to 16 with a spill pending; a further push stalls.
        movement = MV_PUSH; move_valid = 1'b1;
        repeat (12) cyc();
        chk_eq("t3_n16",      64'(onchip_count),  64'd16);
        chk_eq("t3_req",      64'(mem_req),       64'd1);
        chk_eq("t3_addr",     64'(mem_addr),      64'h1001);
        chk_eq("t3_wdata",    64'(mem_wdata),     64'h5A);
        #1 chk_eq("t3_stall_a", 64'(stall), 64'd1);
        cyc();
        chk_eq("t3_n_held",   64'(onchip_count),  64'd16);
        mem_ack = 1'b1;
        #1 chk_eq("t3_stall_ack", 64'(stall), 64'd1);
        cyc();
        mem_ack = 1'b0;
        chk_eq("t3_n15",      64'(onchip_count),  64'd15);
        chk_eq("t3_s2",       64'(spilled_count), 64'd2);
        chk_eq("t3_drop",     64'(drop_bottom),   64'd1);
        #1 chk_eq("t3_stall_off", 64'(stall), 64'd0);
        cyc();
        chk_eq("t3_n16b",     64'(onchip_count),  64'd16);
        chk_eq("t3_req2",     64'(mem_req),       64'd1);
        chk_eq("t3_addr2",    64'(mem_addr),      64'h1002);

        // Pop-two alone, then pop-two coinciding with the spill ack at N=14.
        movement = MV_POP2;
        #1 chk_eq("t6_stall_a", 64'(stall), 64'd0);
        cyc();
        chk_eq("t6_n14",      64'(onchip_count),  64'd14);
        mem_ack = 1'b1;
        #1 chk_eq("t6_stall_b", 64'(stall), 64'd0);
        cyc();
        mem_ack = 1'b0;
        move_valid = 1'b0; movement = MV_NONE;
        chk_eq("t6_n11",      64'(onchip_count),  64'd11);
        chk_eq("t6_s3",       64'(spilled_count), 64'd3);
        chk_eq("t6_drop",     64'(drop_bottom),   64'd1);
        chk_eq("t6_uflow",    64'(underflow),     64'd0);

        // Pop down to N=0 while a fill is pending; a further pop stalls.
        movement = MV_POP; move_valid = 1'b1;
        repeat (11) cyc();
        chk_eq("t4_n0",       64'(onchip_count),  64'd0);
        chk_eq("t4_s3",       64'(spilled_count), 64'd3);
        chk_eq("t4_req",      64'(mem_req),       64'd1);
        chk_eq("t4_we",       64'(mem_we),        64'd0);
        chk_eq("t4_addr",     64'(mem_addr),      64'h1002);
        #1 chk_eq("t4_stall_a", 64'(stall), 64'd1);
        cyc();
        chk_eq("t4_n0_held",  64'(onchip_count),  64'd0);
        mem_rdata = 32'h0000_1234; mem_ack = 1'b1;
        #1 chk_eq("t4_stall_ack", 64'(stall), 64'd1);
        cyc();
        mem_ack = 1'b0;
        chk_eq("t4_n1",       64'(onchip_count),  64'd1);
        chk_eq("t4_s2",       64'(spilled_count), 64'd2);
        chk_eq("t4_fvalid",   64'(fill_valid),    64'd1);
        chk_eq("t4_fval",     64'(fill_value),    64'h1234);
        #1 chk_eq("t4_stall_off", 64'(stall), 64'd0);
        cyc();
        move_valid = 1'b0; movement = MV_NONE;
        chk_eq("t4_n0b",      64'(onchip_count),  64'd0);
        chk_eq("t5_req",      64'(mem_req),       64'd1);
        chk_eq("t5_addr",     64'(mem_addr),      64'h1001);

        // Reset while the fill request is outstanding; a late ack is ignored.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_eq("t5_req_off",  64'(mem_req),       64'd0);
        chk_eq("t5_n0",       64'(onchip_count),  64'd0);
        chk_eq("t5_s0",       64'(spilled_count), 64'd0);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk_eq("t5_no_fv",    64'(fill_valid),    64'd0);
        chk_eq("t5_req_late", 64'(mem_req),       64'd0);
        chk_eq("t5_s0b",      64'(spilled_count), 64'd0);

        // Pop-two with nothing anywhere: no stall, sticky underflow, N stays 0.
        movement = MV_POP2; move_valid = 1'b1;
        #1 chk_eq("t4_uf_stall", 64'(stall), 64'd0);
        cyc();
        move_valid = 1'b0; movement = MV_NONE;
        chk_eq("t4_uflow",    64'(underflow),     64'd1);
        chk_eq("t4_uf_n",     64'(onchip_count),  64'd0);
        chk_eq("t4_uf_s",     64'(spilled_count), 64'd0);
        cyc();
        chk_eq("t4_uf_stick", 64'(underflow),     64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
